// File: rtl/alu_blocking.sv
// alu_blocking: registered 8-function ALU on unsigned WIDTH-bit operands.
// The result is WIDTH+1 bits wide, so carry, borrow or shifted-out MSB is kept.
// y, out_valid and zero appear one clock after an in_valid capture edge.
module alu_blocking #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH:0]   y,
  output logic             out_valid,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Operands are zero-extended first, so ADD keeps its carry, SUB wraps
  // modulo 2^(WIDTH+1) with the top bit acting as borrow, and SHL keeps
  // the bit shifted out of the operand MSB.
  function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] op_a,
                                            input logic [WIDTH-1:0] op_b,
                                            input logic [2:0]       op_sel);
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] res;
    ext_a = {1'b0, op_a};
    ext_b = {1'b0, op_b};
    res   = '0;
    case (op_sel)
      OP_ADD: res = ext_a + ext_b;
      OP_SUB: res = ext_a - ext_b;
      OP_AND: res = {1'b0, op_a & op_b};
      OP_OR:  res = {1'b0, op_a | op_b};
      OP_XOR: res = {1'b0, op_a ^ op_b};
      OP_NOT: res = {1'b0, ~op_a};
      OP_SHL: res = ext_a << 1;
      OP_SHR: res = {1'b0, op_a >> 1};
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [WIDTH:0] result_d;
  logic           zero_d;
  logic [WIDTH:0] y_q;
  logic           out_valid_q;
  logic           zero_q;

  // Combinational stage: evaluate the selected function on the live inputs.
  always_comb begin
    result_d = alu_op(a, b, sel);
    zero_d   = (result_d == '0);
  end

  // Register stage: capture on qualified edges, hold data otherwise; the
  // valid strobe lasts exactly one cycle per capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b1;
    end else if (in_valid) begin
      y_q         <= result_d;
      out_valid_q <= 1'b1;
      zero_q      <= zero_d;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_blocking.sv
// Directed testbench for alu_blocking with hand-computed expected values.
module tb_alu_blocking;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             in_valid;
  logic [WIDTH:0]   y;
  logic             out_valid;
  logic             zero;

  int checks   = 0;
  int failures = 0;

  alu_blocking #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Check all three outputs at once.
  task automatic chk_out(input string tag, input logic [WIDTH:0] ey,
                         input logic ev, input logic ez);
    chk({tag, ".y"},         {27'd0, y},         {27'd0, ey});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".zero"},      {31'd0, zero},      {31'd0, ez});
  endtask

  // Drive inputs just after an edge, then advance to 1ns after the next edge.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb,
                      input logic [2:0] ts, input logic tv);
    a        = ta;
    b        = tb;
    sel      = ts;
    in_valid = tv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    sel      = '0;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_out("reset", 5'b00000, 1'b0, 1'b1);
    rst = 1'b0;

    // Opcode sweep with a=0101, b=0011, back-to-back captures.
    step(4'b0101, 4'b0011, 3'b000, 1'b1); chk_out("sweep_add", 5'b01000, 1'b1, 1'b0);
    step(4'b0101, 4'b0011, 3'b001, 1'b1); chk_out("sweep_sub", 5'b00010, 1'b1, 1'b0);
    step(4'b0101, 4'b0011, 3'b010, 1'b1); chk_out("sweep_and", 5'b00001, 1'b1, 1'b0);
    step(4'b0101, 4'b0011, 3'b011, 1'b1); chk_out("sweep_or",  5'b00111, 1'b1, 1'b0);
    step(4'b0101, 4'b0011, 3'b100, 1'b1); chk_out("sweep_xor", 5'b00110, 1'b1, 1'b0);
    step(4'b0101, 4'b0011, 3'b101, 1'b1); chk_out("sweep_not", 5'b01010, 1'b1, 1'b0);
    step(4'b0101, 4'b0011, 3'b110, 1'b1); chk_out("sweep_shl", 5'b01010, 1'b1, 1'b0);
    step(4'b0101, 4'b0011, 3'b111, 1'b1); chk_out("sweep_shr", 5'b00010, 1'b1, 1'b0);

    // Carry, borrow and shifted-out MSB.
    step(4'b1111, 4'b1111, 3'b000, 1'b1); chk_out("add_carry",  5'b11110, 1'b1, 1'b0);
    step(4'b0000, 4'b0001, 3'b001, 1'b1); chk_out("sub_borrow", 5'b11111, 1'b1, 1'b0);
    step(4'b1000, 4'b0110, 3'b110, 1'b1); chk_out("shl_msb",    5'b10000, 1'b1, 1'b0);

    // Zero flag cases.
    step(4'b0110, 4'b0110, 3'b001, 1'b1); chk_out("sub_zero", 5'b00000, 1'b1, 1'b1);
    step(4'b1111, 4'b1010, 3'b101, 1'b1); chk_out("not_zero", 5'b00000, 1'b1, 1'b1);
    step(4'b0001, 4'b1111, 3'b111, 1'b1); chk_out("shr_zero", 5'b00000, 1'b1, 1'b1);

    // Hold: one capture, then three idle cycles with changing inputs.
    step(4'b0101, 4'b0011, 3'b000, 1'b1); chk_out("hold_cap", 5'b01000, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 3'b101, 1'b0); chk_out("hold1",    5'b01000, 1'b0, 1'b0);
    step(4'b0000, 4'b0110, 3'b001, 1'b0); chk_out("hold2",    5'b01000, 1'b0, 1'b0);
    step(4'b0001, 4'b1001, 3'b111, 1'b0); chk_out("hold3",    5'b01000, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle while y is nonzero.
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 5'b00000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b0000, 4'b0000, 3'b000, 1'b0);

    // Reset collision: a valid ADD on the same edge that rst is high.
    a        = 4'b0111;
    b        = 4'b0111;
    sel      = 3'b000;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk_out("rst_collide", 5'b00000, 1'b0, 1'b1);
    rst = 1'b0;
    step(4'b0010, 4'b0011, 3'b000, 1'b1); chk_out("post_rst_add", 5'b00101, 1'b1, 1'b0);
    step(4'b0010, 4'b0011, 3'b000, 1'b0); chk_out("post_rst_idle", 5'b00101, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against an unexpected hang.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_blocking.md
Name: alu_blocking

Overview:
- Registered 8-function ALU for small unsigned operands: arithmetic, bitwise logic, inversion and 1-bit shifts.
- Result is one bit wider than the operands so carry, borrow or shifted-out MSB is kept.
- Sits as a leaf datapath block.
- Samples operands and opcode on a qualified clock edge; presents a registered result with valid and zero flags one cycle later.

Parameters:
- WIDTH, 4, operand width in bits; result width is WIDTH+1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- sel  input  3  operation select.
- in_valid  input  1  qualifies a/b/sel for capture this cycle.
- y  output  WIDTH+1  registered result.
- out_valid  output  1  high for exactly one cycle when y holds a newly computed result.
- zero  output  1  registered flag, high when y == 0.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately regardless of clk):
  - y = 0, out_valid = 0, zero = 1.
  - State is held while rst stays high.
  - Deassertion is sampled at the next rising edge.
- Capture: on a rising clk edge with rst=0 and in_valid=1, compute f(a,b,sel) combinationally and register it into y. Set zero = (result == 0) and out_valid = 1.
- Latency: exactly 1 cycle from the in_valid edge to y/out_valid.
- Throughput: one operation per cycle; back-to-back in_valid is allowed.
- Hold: on a rising edge with in_valid=0, y and zero hold their previous values and out_valid = 0.
- Operations; all operands are zero-extended to WIDTH+1 before the operation:
  - 000 ADD: y = a + b; y[WIDTH] is the carry out.
  - 001 SUB: y = {0,a} - {0,b} modulo 2^(WIDTH+1). y[WIDTH] = 1 means borrow (a < b); the value is then the two's-complement of the negative difference.
  - 010 AND: y = {0, a & b}.
  - 011 OR: y = {0, a | b}.
  - 100 XOR: y = {0, a ^ b}.
  - 101 NOT: y = {0, ~a}; b is ignored.
  - 110 SHL: y = {0,a} << 1, so y[WIDTH] = a[WIDTH-1] and y[0] = 0; b is ignored.
  - 111 SHR: y = {0, a >> 1}, logical with zero fill; a[0] is discarded; b is ignored.
- No X propagation: every sel value is defined, so there is no default/latch path.
- Boundaries:
  - ADD 15+15 = 11110.
  - SUB 0-1 = 11111.
  - SUB a==b gives y = 0, zero = 1.
  - NOT 1111 gives y = 0, zero = 1.
  - SHR 0001 gives y = 0, zero = 1.
- Reset mid-operation: a capture pending on the same edge that rst asserts is discarded. The first capture possible is on the first rising edge with rst low.
- Inputs changing between edges have no effect on outputs.

Test Plan:
- Reset: assert rst mid-cycle with y nonzero -> y=00000, zero=1, out_valid=0 immediately, before the next clk edge.
- a=0101, b=0011, in_valid=1, sweep sel 000..111 one per cycle -> y sequence 01000, 00010, 00001, 00111, 00110, 01010, 01010, 00010, each one cycle after its sel, with out_valid=1 on every cycle.
- Carry/borrow:
  - a=1111, b=1111, ADD -> 11110.
  - a=0000, b=0001, SUB -> 11111.
  - a=1000, SHL -> 10000.
- Zero flag:
  - a=0110, b=0110, SUB -> y=0, zero=1.
  - a=1111, NOT -> y=0, zero=1.
  - a=0001, SHR -> y=0, zero=1.
- Hold: after a capture of a=0101, b=0011, ADD, drop in_valid and change a/b/sel for 3 cycles -> y stays 01000, zero=0, out_valid=0.
- Reset collision: drive in_valid=1 with an ADD and assert rst on the same edge -> y=0, out_valid=0. After release, the next valid ADD 2+3 -> 00101 one cycle later.
